// File: rtl/mem_access.sv
// MIPS MEM stage: byte/half/word loads and stores on an internal word memory with a wait-state FSM.
// Optional MEM_ACCESS_PERF_EN adds load/store/stall event counters.
module mem_access #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       store_data;
  logic [3:0]        lane_en;
  logic              req;
  logic              valid;
  logic              complete;
  logic              is_load;
  logic              unused_addr;

  assign unused_addr = ^alu_res[31:ADDR_W+2];

  assign req        = mem_read | mem_write;
  assign misaligned = req && ((size == 2'b01 && alu_res[0]) || (size[1] && alu_res[1:0] != 2'b00));
  assign valid      = req && !misaligned;
  assign is_load    = mem_read && !mem_write;
  assign idx        = alu_res[ADDR_W+1:2];
  assign word       = mem[idx];

  // An access completes either immediately (no wait states) or once BUSY has counted down.
  assign complete = valid && ((state == IDLE && WAIT_STATES == 0) || (state == BUSY && cnt == 4'd0));
  assign stall    = valid && !rst && ((state == IDLE && WAIT_STATES > 0) || (state == BUSY && cnt != 4'd0));

  always_comb begin
    byte_sel = word[8*alu_res[1:0] +: 8];
    half_sel = alu_res[1] ? word[31:16] : word[15:0];
    read_data = 32'h0;
    if (complete && is_load) begin
      case (size)
        2'b00:   read_data = load_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        2'b01:   read_data = load_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        default: read_data = word;
      endcase
    end
  end

  always_comb begin
    case (size)
      2'b00: begin
        store_data = {4{write_data[7:0]}};
        lane_en    = 4'b0001 << alu_res[1:0];
      end
      2'b01: begin
        store_data = {2{write_data[15:0]}};
        lane_en    = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = write_data;
        lane_en    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && complete && mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && WAIT_STATES > 0) begin
            state <= BUSY;
            cnt   <= 4'(WAIT_STATES - 1);
          end
        end
        BUSY: begin
          if (!valid || cnt == 4'd0) state <= IDLE;
          else                       cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= 32'h0;
      store_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (complete && is_load)   load_cnt  <= load_cnt + 32'h1;
      if (complete && mem_write) store_cnt <= store_cnt + 32'h1;
      if (stall)                 stall_cnt <= stall_cnt + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboarded bench for mem_access: stimulus pushes expected completions, a negedge monitor checks them.
module tb_mem_access;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_res, write_data;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  size;
  logic [31:0] read_data;
  logic        stall, misaligned;

  logic [31:0] z_alu_res, z_write_data;
  logic        z_mem_read, z_mem_write, z_load_unsigned;
  logic [1:0]  z_size;
  logic [31:0] z_read_data;
  logic        z_stall, z_misaligned;

`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] load_cnt, store_cnt, stall_cnt;
  logic [31:0] z_load_cnt, z_store_cnt, z_stall_cnt;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  mem_access #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .alu_res(alu_res), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .read_data(read_data), .stall(stall),
    .misaligned(misaligned)
`ifdef MEM_ACCESS_PERF_EN
    , .load_cnt(load_cnt), .store_cnt(store_cnt), .stall_cnt(stall_cnt)
`endif
  );

  mem_access #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .alu_res(z_alu_res), .write_data(z_write_data),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .size(z_size),
    .load_unsigned(z_load_unsigned), .read_data(z_read_data), .stall(z_stall),
    .misaligned(z_misaligned)
`ifdef MEM_ACCESS_PERF_EN
    , .load_cnt(z_load_cnt), .store_cnt(z_store_cnt), .stall_cnt(z_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // A completion is any cycle with a request present and no stall.
  always @(negedge clk) begin
    if (!rst && (mem_read || mem_write) && !stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("read_data", read_data, e.rd);
        check("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis);
    int n;
    mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns;
    alu_res = addr; write_data = wd;
    exp_q.push_back('{exp_rd, exp_mis});
    n = exp_mis ? 0 : WS;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      check("stall", {31'h0, stall}, 32'(k < n));
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b10; load_unsigned = 1'b0;
    alu_res = 32'h0; write_data = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic zaccess(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    z_mem_read = rd; z_mem_write = wr; z_size = sz; z_load_unsigned = uns;
    z_alu_res = addr; z_write_data = wd;
    @(negedge clk);
    check("ws0_stall", {31'h0, z_stall}, 32'h0);
    check("ws0_read_data", z_read_data, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b10; load_unsigned = 1'b0;
    alu_res = 32'h0; write_data = 32'h0;
    z_mem_read = 1'b0; z_mem_write = 1'b0; z_size = 2'b10; z_load_unsigned = 1'b0;
    z_alu_res = 32'h0; z_write_data = 32'h0;
    @(negedge clk);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_read_data", read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // word store/load and sub-word lanes
    access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access(0, 1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0, 0);
    access(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    access(1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    access(0, 1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0, 0);
    access(1, 0, 2'b01, 0, 32'h12, 32'h0, 32'h00001234, 0);
    access(1, 0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
    access(1, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0);
    access(1, 0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
    idle();

    // misaligned: no stall, no data, store suppressed
    access(1, 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1);
    access(0, 1, 2'b10, 0, 32'h00, 32'h11223344, 32'h0, 0);
    access(0, 1, 2'b01, 0, 32'h01, 32'h0000AAAA, 32'h0, 1);
    access(1, 0, 2'b10, 0, 32'h00, 32'h0, 32'h11223344, 0);

    // address wrap
    access(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0, 0);
    access(1, 0, 2'b10, 0, 32'h000, 32'h0, 32'hCAFEF00D, 0);

    // reset mid-store aborts the write
    access(0, 1, 2'b10, 0, 32'h20, 32'h55667788, 32'h0, 0);
    idle();
    mem_write = 1'b1; size = 2'b10; alu_res = 32'h20; write_data = 32'h99999999;
    @(negedge clk);
    check("abort_stall_c1", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("abort_stall_after", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;

    // three loads and one store for the event counters
    access(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h55667788, 0);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0);
    access(1, 0, 2'b10, 0, 32'h00, 32'h0, 32'hCAFEF00D, 0);
    access(0, 1, 2'b10, 0, 32'h40, 32'h00000001, 32'h0, 0);
    idle();
`ifdef MEM_ACCESS_PERF_EN
    check("load_cnt", load_cnt, 32'd3);
    check("store_cnt", store_cnt, 32'd1);
    check("stall_cnt", stall_cnt, 32'd8);
`endif

    // read and write together: store wins
    access(1, 1, 2'b10, 0, 32'h30, 32'h0BADCAFE, 32'h0, 0);
    access(1, 0, 2'b10, 0, 32'h30, 32'h0, 32'h0BADCAFE, 0);
    idle();

    // zero wait states: single-cycle completion
    zaccess(0, 1, 2'b10, 0, 32'h08, 32'h13579BDF, 32'h0);
    zaccess(1, 0, 2'b10, 0, 32'h08, 32'h0, 32'h13579BDF);
    zaccess(1, 0, 2'b00, 1, 32'h0B, 32'h0, 32'h00000013);
    zaccess(1, 0, 2'b00, 0, 32'h09, 32'h0, 32'hFFFFFF9B);
    zaccess(0, 0, 2'b10, 0, 32'h08, 32'h0, 32'h0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
